// File: rtl/tds_readout_pkg.sv
// Shared types and defaults for the TDS readout path.
package tds_readout_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 120;
  localparam int unsigned LEN_W  = 12;
  localparam int unsigned CH_W   = $clog2(NUM_CH);

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef struct packed {
    logic            hit;
    logic [CH_W-1:0] idx;
  } rr_pick_t;

  // Round-robin search starting one past the last grant.
  function automatic rr_pick_t rr_next(input logic [NUM_CH-1:0] req,
                                       input logic [CH_W-1:0]   last);
    rr_pick_t        res;
    logic [CH_W-1:0] cand;
    res = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((32'(last) + k) % NUM_CH);
      if (!res.hit && req[cand]) begin
        res.hit = 1'b1;
        res.idx = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_priority_pick #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_i,
  output logic [CH_W-1:0]   idx_o,
  output logic              hit_o
);

  // Scan NUM_CH positions beginning at last_i+1; the first set bit wins.
  always_comb begin
    logic            found;
    logic [CH_W-1:0] cand;
    logic [CH_W-1:0] idx;
    found = 1'b0;
    cand  = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((32'(last_i) + k) % NUM_CH);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    hit_o = found;
    idx_o = idx;
  end

endmodule

// File: rtl/tds_channel_read_arbiter.sv
// Round-robin burst reader sharing one readout path among the channel FIFOs.
module tds_channel_read_arbiter #(
  parameter int unsigned NUM_CH = tds_readout_pkg::NUM_CH,
  parameter int unsigned DATA_W = tds_readout_pkg::DATA_W,
  parameter int unsigned LEN_W  = tds_readout_pkg::LEN_W,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [LEN_W-1:0]         burst_limit,
  input  logic [NUM_CH-1:0]        fifo_empty,
  input  logic [NUM_CH*DATA_W-1:0] fifo_data,
  output logic [NUM_CH-1:0]        fifo_read,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     burst_done,
  output logic [CH_W-1:0]          burst_ch,
  output logic [LEN_W-1:0]         burst_len,
  output logic                     busy
);

  import tds_readout_pkg::*;

  arb_state_t        state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic              burst_done_q, burst_done_d;
  logic [CH_W-1:0]   burst_ch_q, burst_ch_d;
  logic [LEN_W-1:0]  burst_len_q, burst_len_d;

  logic [NUM_CH-1:0] req;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_hit;
  logic [DATA_W-1:0] fifo_word [NUM_CH];
  logic [LEN_W-1:0]  limit_eff;
  logic [LEN_W:0]    cnt_inc;
  logic              head_empty, head_en, pop;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign fifo_word[g] = fifo_data[g*DATA_W +: DATA_W];
  end

  assign req = ch_enable & ~fifo_empty;

  rr_priority_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req_i  (req),
    .last_i (last_grant_q),
    .idx_o  (pick_idx),
    .hit_o  (pick_hit)
  );

  // Pop qualification; reset blocks pops so the FIFOs are left untouched.
  always_comb begin
    head_empty = fifo_empty[grant_q];
    head_en    = ch_enable[grant_q];
    limit_eff  = (burst_limit == '0) ? LEN_W'(1) : burst_limit;
    cnt_inc    = {1'b0, word_cnt_q} + (LEN_W + 1)'(1);
    pop        = (state_q == GRANT) && !head_empty && head_en &&
                 (!out_valid_q || out_ready) && !reset;
    fifo_read  = '0;
    if (pop) fifo_read[grant_q] = 1'b1;
  end

  // Next-state: arbitration, burst termination and the output register stage.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_valid_d  = out_valid_q;
    burst_done_d = 1'b0;
    burst_ch_d   = burst_ch_q;
    burst_len_d  = burst_len_q;

    if (pop) begin
      out_data_d  = fifo_word[grant_q];
      out_ch_d    = grant_q;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (pick_hit) begin
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          word_cnt_d   = '0;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        if (pop) begin
          word_cnt_d = cnt_inc[LEN_W-1:0];
          // >= so a limit lowered below the running count ends on this pop.
          if (cnt_inc >= {1'b0, limit_eff}) begin
            state_d      = IDLE;
            burst_done_d = 1'b1;
            burst_ch_d   = grant_q;
            burst_len_d  = cnt_inc[LEN_W-1:0];
          end
        end else if (head_empty || !head_en) begin
          state_d = IDLE;
          // With nothing popped yet this was an entry race: leave silently.
          if (word_cnt_q != '0) begin
            burst_done_d = 1'b1;
            burst_ch_d   = grant_q;
            burst_len_d  = word_cnt_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      word_cnt_q   <= '0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      burst_done_q <= 1'b0;
      burst_ch_q   <= '0;
      burst_len_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_valid_q  <= out_valid_d;
      burst_done_q <= burst_done_d;
      burst_ch_q   <= burst_ch_d;
      burst_len_q  <= burst_len_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign out_valid  = out_valid_q;
  assign burst_done = burst_done_q;
  assign burst_ch   = burst_ch_q;
  assign burst_len  = burst_len_q;
  assign busy       = (state_q == GRANT) || out_valid_q;

endmodule

// File: tb/tb_tds_channel_read_arbiter.sv
// Bench for tds_channel_read_arbiter: emulated FWFT FIFOs plus a queue-based burst model.
module tb_tds_channel_read_arbiter;
  import tds_readout_pkg::*;

  localparam int unsigned NCH   = NUM_CH;
  localparam int unsigned DW    = DATA_W;
  localparam int unsigned LW    = LEN_W;
  localparam int unsigned CW    = $clog2(NUM_CH);
  localparam int unsigned DEPTH = 1024;

  typedef logic [CW+DW-1:0] acc_t;
  typedef logic [CW+LW-1:0] bd_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ch_enable;
  logic [LW-1:0]     burst_limit;
  logic [NCH-1:0]    fifo_empty;
  logic [NCH*DW-1:0] fifo_data;
  logic [NCH-1:0]    fifo_read;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_ch;
  logic              out_valid;
  logic              out_ready;
  logic              burst_done;
  logic [CW-1:0]     burst_ch;
  logic [LW-1:0]     burst_len;
  logic              busy;

  tds_channel_read_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .ch_enable   (ch_enable),
    .burst_limit (burst_limit),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read   (fifo_read),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .burst_done  (burst_done),
    .burst_ch    (burst_ch),
    .burst_len   (burst_len),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // FWFT FIFO emulation
  logic [DW-1:0] mem [NCH][DEPTH];
  int unsigned   wr_ptr [NCH];
  int unsigned   rd_ptr [NCH];
  int unsigned   pop_cnt [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_fifo
    assign fifo_empty[g]         = (rd_ptr[g] == wr_ptr[g]);
    assign fifo_data[g*DW +: DW] = mem[g][rd_ptr[g] % DEPTH];
  end

  // Monitor state
  int     cyc = 0;
  int     first_pop_cyc = -1;
  int     bp_viol = 0, oh_viol = 0, stall_viol = 0, underflow = 0;
  logic   stall_prev = 1'b0;
  logic [DW-1:0] stall_data;
  logic [CW-1:0] stall_ch;
  acc_t   acc_q[$];
  int     acc_cyc[$];
  bd_t    bd_q[$];
  int     bd_cyc[$];

  // Reference model: per-channel contents and last granted channel.
  logic [DW-1:0] mq [NCH][$];
  int            model_last;

  int checks = 0;
  int errors = 0;

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (fifo_read[i]) begin
        if (rd_ptr[i] == wr_ptr[i]) underflow++;
        rd_ptr[i] <= rd_ptr[i] + 1;
        pop_cnt[i]++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
    end
    if (!reset) begin
      if (out_valid && out_ready) begin
        acc_q.push_back({out_ch, out_data});
        acc_cyc.push_back(cyc);
      end
      if (burst_done) begin
        bd_q.push_back({burst_ch, burst_len});
        bd_cyc.push_back(cyc);
      end
      if ((|fifo_read) && out_valid && !out_ready) bp_viol++;
      if ($countones(fifo_read) > 1) oh_viol++;
      if (stall_prev && (!out_valid || out_data !== stall_data || out_ch !== stall_ch))
        stall_viol++;
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_ch   = out_ch;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int ch);
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    mem[ch][wr_ptr[ch] % DEPTH] = r[DW-1:0];
    mq[ch].push_back(r[DW-1:0]);
    wr_ptr[ch]++;
  endtask

  task automatic fill(input int ch, input int n);
    for (int j = 0; j < n; j++) push_word(ch);
  endtask

  task automatic clear_logs();
    acc_q.delete();
    acc_cyc.delete();
    bd_q.delete();
    bd_cyc.delete();
  endtask

  // Drain all enabled data under a fixed limit and compare bursts and words to the model.
  task automatic run_drain(input logic [NCH-1:0] en, input int lim, input int mode,
                           input string name);
    bd_t  exp_b[$];
    acc_t exp_w[$];
    int   last, c, n, eff;
    bit   found, to;
    last = model_last;
    eff  = (lim == 0) ? 1 : lim;
    forever begin
      found = 0;
      c = 0;
      for (int k = 1; k <= NCH; k++) begin
        if (!found && en[(last + k) % NCH] && mq[(last + k) % NCH].size() > 0) begin
          found = 1;
          c = (last + k) % NCH;
        end
      end
      if (!found) break;
      n = (mq[c].size() < eff) ? mq[c].size() : eff;
      for (int j = 0; j < n; j++) exp_w.push_back({CW'(c), mq[c].pop_front()});
      exp_b.push_back({CW'(c), LW'(n)});
      last = c;
    end
    model_last = last;

    ch_enable   = en;
    burst_limit = LW'(lim);
    clear_logs();
    to = 1;
    for (int t = 0; t < 3000; t++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (t % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (bd_q.size() >= exp_b.size() && !busy) begin
        to = 0;
        break;
      end
    end
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk({name, " timeout"}, to, 0);
    chk({name, " bursts"}, bd_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < bd_q.size(); i++)
      chk({name, " burst"}, bd_q[i], exp_b[i]);
    chk({name, " words"}, acc_q.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < acc_q.size(); i++)
      chk({name, " word"}, acc_q[i], exp_w[i]);
  endtask

  int c0, base1, bd_before;
  int snap [NCH];
  bit to;

  initial begin
    for (int i = 0; i < NCH; i++) begin
      wr_ptr[i]  = 0;
      rd_ptr[i]  = 0;
      pop_cnt[i] = 0;
    end
    reset       = 1'b1;
    ch_enable   = '0;
    burst_limit = LW'(1);
    out_ready   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst fifo_read", fifo_read, 0);
    chk("rst busy", busy, 0);
    chk("rst burst_done", burst_done, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_ch", out_ch, 0);
    chk("rst burst_ch", burst_ch, 0);
    chk("rst burst_len", burst_len, 0);
    reset = 1'b0;
    model_last = NCH - 1;
    @(negedge clk);

    // Four full channels, limit 4: 0,1,2,3 x2 with 4 words, then 2 words each.
    for (int i = 0; i < NCH; i++) fill(i, 10);
    run_drain('1, 4, 0, "rr4");
    chk("rr4 total", acc_q.size(), 40);

    // Ch0 with three words: latency and back-to-back throughput.
    fill(0, 3);
    c0 = cyc;
    first_pop_cyc = -1;
    run_drain('1, 8, 0, "ch0x3");
    chk("ch0x3 first pop cycle", first_pop_cyc, c0 + 2);
    if (acc_cyc.size() >= 3 && bd_cyc.size() >= 1) begin
      chk("ch0x3 word0 cycle", acc_cyc[0], c0 + 3);
      chk("ch0x3 word1 cycle", acc_cyc[1], c0 + 4);
      chk("ch0x3 word2 cycle", acc_cyc[2], c0 + 5);
      chk("ch0x3 done cycle", bd_cyc[0], c0 + 6);
    end

    // Toggling ready on a five-word ch2 burst.
    fill(2, 5);
    run_drain('1, 8, 1, "ready_toggle");
    chk("ready_toggle backpressure", bp_viol, 0);
    chk("ready_toggle stable", stall_viol, 0);

    // Ch1 disabled after two pops; ch3 gets the next grant.
    fill(1, 6);
    ch_enable   = '1;
    burst_limit = LW'(8);
    out_ready   = 1'b1;
    clear_logs();
    base1 = pop_cnt[1];
    to = 1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (pop_cnt[1] == base1 + 1) begin
        to = 0;
        break;
      end
    end
    fill(3, 2);
    for (int t = 0; t < 100 && !to; t++) begin
      if (pop_cnt[1] == base1 + 2) break;
      @(negedge clk);
      if (t == 99) to = 1;
    end
    ch_enable[1] = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bd_q.size() >= 2 && !busy) break;
    end
    repeat (3) @(negedge clk);
    chk("en_drop timeout", to, 0);
    chk("en_drop bursts", bd_q.size(), 2);
    if (bd_q.size() >= 2) begin
      chk("en_drop burst ch1", bd_q[0], {CW'(1), LW'(2)});
      chk("en_drop burst ch3", bd_q[1], {CW'(3), LW'(2)});
    end
    chk("en_drop ch1 left", wr_ptr[1] - rd_ptr[1], 4);
    chk("en_drop words", acc_q.size(), 4);
    if (acc_q.size() >= 4) begin
      chk("en_drop w0", acc_q[0], {CW'(1), mq[1][0]});
      chk("en_drop w1", acc_q[1], {CW'(1), mq[1][1]});
      chk("en_drop w2", acc_q[2], {CW'(3), mq[3][0]});
      chk("en_drop w3", acc_q[3], {CW'(3), mq[3][1]});
    end
    for (int j = 0; j < 2; j++) begin
      void'(mq[1].pop_front());
      void'(mq[3].pop_front());
    end
    model_last = 3;
    run_drain('1, 3, 2, "ch1_rest");

    // Limit 0 behaves as 1.
    fill(0, 3);
    run_drain('1, 0, 0, "limit0");

    // Reset during a stalled burst.
    fill(1, 3);
    fill(2, 3);
    for (int i = 0; i < NCH; i++) snap[i] = pop_cnt[i];
    ch_enable   = '1;
    burst_limit = LW'(8);
    out_ready   = 1'b0;
    clear_logs();
    to = 1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (out_valid) begin
        to = 0;
        break;
      end
    end
    chk("rst_mid valid seen", to, 0);
    bd_before = bd_q.size();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid out_valid", out_valid, 0);
    chk("rst_mid fifo_read", fifo_read, 0);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid burst_done", burst_done, 0);
    reset = 1'b0;
    chk("rst_mid no report", bd_q.size(), bd_before);
    for (int i = 0; i < NCH; i++)
      for (int j = snap[i]; j < pop_cnt[i]; j++) void'(mq[i].pop_front());
    model_last = NCH - 1;
    run_drain('1, 8, 0, "post_reset");
    if (bd_q.size() >= 1) chk("post_reset first ch", bd_q[0][CW+LW-1:LW], 1);

    // Randomized drains under random masks, limits and ready patterns.
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NCH; i++) fill(i, $urandom_range(0, 9));
      run_drain(NCH'($urandom_range(1, (1 << NCH) - 1)), $urandom_range(0, 6),
                $urandom_range(0, 2), "rand");
    end
    run_drain('1, 5, 2, "final_drain");

    chk("backpressure pops", bp_viol, 0);
    chk("one-hot pops", oh_viol, 0);
    chk("stalled data stable", stall_viol, 0);
    chk("fifo underflow", underflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
